// File: rtl/multicycle_sequencer_pkg.sv
// Shared definitions for the multi-cycle control sequencer: opcodes, FSM states,
// instruction classes, ALU function codes and datapath select encodings.
package seq_pkg;

    // Primary opcodes held in IR[15:12]
    localparam logic [3:0] OP_ADD   = 4'b0000;
    localparam logic [3:0] OP_SUB   = 4'b0001;
    localparam logic [3:0] OP_NAND  = 4'b0010;
    localparam logic [3:0] OP_UNARY = 4'b0011;
    localparam logic [3:0] OP_NOR   = 4'b0100;
    localparam logic [3:0] OP_PUSH  = 4'b0110;
    localparam logic [3:0] OP_LW    = 4'b1000;
    localparam logic [3:0] OP_SW    = 4'b1001;
    localparam logic [3:0] OP_JMP   = 4'b1100;
    localparam logic [3:0] OP_BEQ   = 4'b1101;
    localparam logic [3:0] OP_POP   = 4'b1110;
    localparam logic [3:0] OP_LWC   = 4'b1111;

    // Sub-function codes for the unary/shift opcode, held in IR[3:0]
    localparam logic [3:0] FN_NEG = 4'b0000;
    localparam logic [3:0] FN_SAR = 4'b0001;
    localparam logic [3:0] FN_SHR = 4'b0010;
    localparam logic [3:0] FN_SHL = 4'b0011;

    typedef enum logic [2:0] {
        FETCH,
        DECODE,
        EXEC,
        MEM,
        TRAP
    } seqState_t;

    typedef enum logic [3:0] {
        CL_ALU,
        CL_BEQ,
        CL_JMP,
        CL_LW,
        CL_SW,
        CL_LWC,
        CL_PUSH,
        CL_POP,
        CL_ILLEGAL
    } instrClass_t;

    // ALU function codes
    localparam logic [2:0] ALU_ADD  = 3'b000;
    localparam logic [2:0] ALU_SUB  = 3'b001;
    localparam logic [2:0] ALU_NAND = 3'b010;
    localparam logic [2:0] ALU_NOR  = 3'b011;
    localparam logic [2:0] ALU_NEG  = 3'b100;
    localparam logic [2:0] ALU_SAR  = 3'b101;
    localparam logic [2:0] ALU_SHR  = 3'b110;
    localparam logic [2:0] ALU_SHL  = 3'b111;

    // ALU operand A select
    localparam logic [1:0] A_S1    = 2'b00;
    localparam logic [1:0] A_SP    = 2'b01;
    localparam logic [1:0] A_SHAMT = 2'b10;

    // ALU operand B select
    localparam logic [1:0] B_ONE = 2'b00;
    localparam logic [1:0] B_S2  = 2'b01;
    localparam logic [1:0] B_RD  = 2'b10;

    // Data-memory address select
    localparam logic [1:0] ADDR_LW = 2'b00;
    localparam logic [1:0] ADDR_SW = 2'b01;
    localparam logic [1:0] ADDR_SP = 2'b10;
    localparam logic [1:0] ADDR_S1 = 2'b11;

    // Next-PC source select
    localparam logic [1:0] PC_INC    = 2'b00;
    localparam logic [1:0] PC_BRANCH = 2'b01;
    localparam logic [1:0] PC_JUMP   = 2'b10;

    // True for the classes that need a data-memory phase
    function automatic logic isMemClass(input instrClass_t c);
        return (c == CL_LW) || (c == CL_SW) || (c == CL_LWC) ||
               (c == CL_PUSH) || (c == CL_POP);
    endfunction

endpackage

// File: rtl/multicycle_sequencer_if.sv
// Instruction/data memory handshake bundle between the sequencer (master)
// and the memory side (slave).
interface multicycle_sequencer_if;

    logic [15:0] instr;
    logic        imem_req;
    logic        imem_ready;
    logic        dmem_req;
    logic        dmem_we;
    logic [1:0]  dmem_addr_sel;
    logic        dmem_ready;

    modport master (
        output imem_req,
        input  imem_ready,
        input  instr,
        output dmem_req,
        output dmem_we,
        output dmem_addr_sel,
        input  dmem_ready
    );

    modport slave (
        input  imem_req,
        output imem_ready,
        output instr,
        input  dmem_req,
        input  dmem_we,
        input  dmem_addr_sel,
        output dmem_ready
    );

endinterface

// File: rtl/multicycle_sequencer_instr_class_decode.sv
// Combinational instruction classifier: maps the IR onto an instruction class
// plus the ALU function and datapath selects that class needs.
module instr_class_decode
    import seq_pkg::*;
(
    input  logic [15:0] ir,
    output instrClass_t instrClass,
    output logic [2:0]  aluOp,
    output logic [1:0]  aluASel,
    output logic [1:0]  aluBSel,
    output logic [1:0]  dmemAddrSel,
    output logic        illegal
);

    logic [3:0] opcode;
    logic [3:0] funct;
    logic       unusedIrBits;

    assign opcode       = ir[15:12];
    assign funct        = ir[3:0];
    assign unusedIrBits = ^ir[11:4];

    // Classify the opcode; anything not recognised stays CL_ILLEGAL
    always_comb begin
        instrClass  = CL_ILLEGAL;
        aluOp       = ALU_ADD;
        aluASel     = A_S1;
        aluBSel     = B_ONE;
        dmemAddrSel = ADDR_LW;
        case (opcode)
            OP_ADD:  begin instrClass = CL_ALU; aluOp = ALU_ADD;  aluBSel = B_S2; end
            OP_SUB:  begin instrClass = CL_ALU; aluOp = ALU_SUB;  aluBSel = B_S2; end
            OP_NAND: begin instrClass = CL_ALU; aluOp = ALU_NAND; aluBSel = B_S2; end
            OP_NOR:  begin instrClass = CL_ALU; aluOp = ALU_NOR;  aluBSel = B_S2; end
            OP_UNARY: begin
                case (funct)
                    FN_NEG: begin instrClass = CL_ALU; aluOp = ALU_NEG; aluBSel = B_S2; end
                    FN_SAR: begin instrClass = CL_ALU; aluOp = ALU_SAR; aluASel = A_SHAMT; aluBSel = B_RD; end
                    FN_SHR: begin instrClass = CL_ALU; aluOp = ALU_SHR; aluASel = A_SHAMT; aluBSel = B_RD; end
                    FN_SHL: begin instrClass = CL_ALU; aluOp = ALU_SHL; aluASel = A_SHAMT; aluBSel = B_RD; end
                    default: instrClass = CL_ILLEGAL;
                endcase
            end
            OP_BEQ:  begin instrClass = CL_BEQ; aluOp = ALU_SUB; aluBSel = B_S2; end
            OP_JMP:  instrClass = CL_JMP;
            OP_LW:   begin instrClass = CL_LW;  dmemAddrSel = ADDR_LW; end
            OP_SW:   begin instrClass = CL_SW;  dmemAddrSel = ADDR_SW; end
            OP_LWC:  begin instrClass = CL_LWC; dmemAddrSel = ADDR_S1; end
            OP_PUSH: begin instrClass = CL_PUSH; dmemAddrSel = ADDR_SP; aluOp = ALU_SUB; aluASel = A_SP; end
            OP_POP:  begin instrClass = CL_POP;  dmemAddrSel = ADDR_SP; aluOp = ALU_ADD; aluASel = A_SP; end
            default: instrClass = CL_ILLEGAL;
        endcase
        illegal = (instrClass == CL_ILLEGAL);
    end

endmodule

// File: rtl/multicycle_sequencer.sv
// Multi-cycle control sequencer for the 16-bit core: FETCH/DECODE/EXEC/MEM
// phases, data-memory wait timeout, retired-instruction counter.
// Optional macro ILLEGAL_TRAP_EN: illegal opcodes lock the FSM in TRAP and
// drive the extra 'trap' output; otherwise they execute as a NOP.
module multicycle_sequencer
    import seq_pkg::*;
#(
    parameter int MEM_TIMEOUT = 15,
    parameter int CNT_W       = 16
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                run,
    input  logic                alu_zero,
    multicycle_sequencer_if.master memBus,
    output logic                ir_load,
    output logic                pc_write,
    output logic [1:0]          pc_src,
    output logic [2:0]          alu_op,
    output logic [1:0]          alu_a_sel,
    output logic [1:0]          alu_b_sel,
    output logic                reg_we,
    output logic                reg_src,
    output logic                sp_we,
    output logic                is_pop,
    output logic                retire,
    output logic [CNT_W-1:0]    retired_cnt,
`ifdef ILLEGAL_TRAP_EN
    output logic                trap,
`endif
    output logic                mem_err
);

    localparam logic [7:0] TIMEOUT_LIM = 8'(MEM_TIMEOUT);

    seqState_t   state;
    seqState_t   nextState;
    logic [15:0] ir;
    logic [7:0]  timeoutCnt;
    logic        memAbort;

    instrClass_t instrClass;
    logic [2:0]  decAluOp;
    logic [1:0]  decASel;
    logic [1:0]  decBSel;
    logic [1:0]  decAddrSel;
    logic        illegal;

    instr_class_decode decodeUnit (
        .ir          (ir),
        .instrClass  (instrClass),
        .aluOp       (decAluOp),
        .aluASel     (decASel),
        .aluBSel     (decBSel),
        .dmemAddrSel (decAddrSel),
        .illegal     (illegal)
    );

    // State, IR, wait counter, retire counter and sticky error registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= FETCH;
            ir          <= 16'h0000;
            timeoutCnt  <= 8'd0;
            retired_cnt <= '0;
            mem_err     <= 1'b0;
        end else begin
            state <= nextState;
            if (ir_load) begin
                ir <= memBus.instr;
            end
            if (state == MEM && !memBus.dmem_ready && !memAbort) begin
                timeoutCnt <= timeoutCnt + 8'd1;
            end else begin
                timeoutCnt <= 8'd0;
            end
            if (retire) begin
                retired_cnt <= retired_cnt + CNT_W'(1);
            end
            if (memAbort) begin
                mem_err <= 1'b1;
            end
        end
    end

    // Next-state and per-phase strobe decode from state plus IR class
    always_comb begin
        nextState            = state;
        memBus.imem_req      = 1'b0;
        memBus.dmem_req      = 1'b0;
        memBus.dmem_we       = 1'b0;
        memBus.dmem_addr_sel = ADDR_LW;
        ir_load              = 1'b0;
        pc_write             = 1'b0;
        pc_src               = PC_INC;
        alu_op               = ALU_ADD;
        alu_a_sel            = A_S1;
        alu_b_sel            = B_ONE;
        reg_we               = 1'b0;
        reg_src              = 1'b0;
        sp_we                = 1'b0;
        is_pop               = 1'b0;
        retire               = 1'b0;
        memAbort             = 1'b0;
`ifdef ILLEGAL_TRAP_EN
        trap                 = 1'b0;
`endif
        case (state)
            FETCH: begin
                memBus.imem_req = run && reset_n;
                if (run && reset_n && memBus.imem_ready) begin
                    ir_load   = 1'b1;
                    nextState = DECODE;
                end
            end
            DECODE: begin
                if (illegal) begin
`ifdef ILLEGAL_TRAP_EN
                    nextState = TRAP;
`else
                    nextState = EXEC;
`endif
                end else if (isMemClass(instrClass)) begin
                    nextState = MEM;
                end else begin
                    nextState = EXEC;
                end
            end
            EXEC: begin
                pc_write  = 1'b1;
                retire    = 1'b1;
                nextState = FETCH;
                case (instrClass)
                    CL_ALU: begin
                        reg_we    = 1'b1;
                        alu_op    = decAluOp;
                        alu_a_sel = decASel;
                        alu_b_sel = decBSel;
                    end
                    CL_BEQ: begin
                        alu_op    = decAluOp;
                        alu_a_sel = decASel;
                        alu_b_sel = decBSel;
                        pc_src    = alu_zero ? PC_BRANCH : PC_INC;
                    end
                    CL_JMP:  pc_src = PC_JUMP;
                    default: pc_src = PC_INC;
                endcase
            end
            MEM: begin
                memBus.dmem_addr_sel = decAddrSel;
                alu_op               = decAluOp;
                alu_a_sel            = decASel;
                is_pop               = (instrClass == CL_POP);
                reg_src              = (instrClass == CL_LW) || (instrClass == CL_LWC) ||
                                       (instrClass == CL_POP);
                if (memBus.dmem_ready) begin
                    memBus.dmem_req = 1'b1;
                    memBus.dmem_we  = (instrClass == CL_SW) || (instrClass == CL_PUSH);
                    reg_we          = reg_src;
                    sp_we           = (instrClass == CL_PUSH) || (instrClass == CL_POP);
                    pc_write        = 1'b1;
                    retire          = 1'b1;
                    nextState       = FETCH;
                end else if (timeoutCnt == TIMEOUT_LIM) begin
                    memAbort  = 1'b1;
                    pc_write  = 1'b1;
                    nextState = FETCH;
                end else begin
                    memBus.dmem_req = 1'b1;
                    memBus.dmem_we  = (instrClass == CL_SW) || (instrClass == CL_PUSH);
                end
            end
            TRAP: begin
`ifdef ILLEGAL_TRAP_EN
                trap = 1'b1;
`endif
                nextState = TRAP;
            end
            default: nextState = FETCH;
        endcase
    end

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Directed testbench for multicycle_sequencer (MEM_TIMEOUT=4); covers both
// builds of the ILLEGAL_TRAP_EN option.
module tb_multicycle_sequencer;

    logic        clk;
    logic        reset_n;
    logic        run;
    logic        alu_zero;
    logic        ir_load;
    logic        pc_write;
    logic [1:0]  pc_src;
    logic [2:0]  alu_op;
    logic [1:0]  alu_a_sel;
    logic [1:0]  alu_b_sel;
    logic        reg_we;
    logic        reg_src;
    logic        sp_we;
    logic        is_pop;
    logic        retire;
    logic [15:0] retired_cnt;
    logic        mem_err;
`ifdef ILLEGAL_TRAP_EN
    logic        trap;
`endif

    int checks = 0;
    int errors = 0;

    multicycle_sequencer_if memBus();

    multicycle_sequencer #(
        .MEM_TIMEOUT (4),
        .CNT_W       (16)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .run         (run),
        .alu_zero    (alu_zero),
        .memBus      (memBus),
        .ir_load     (ir_load),
        .pc_write    (pc_write),
        .pc_src      (pc_src),
        .alu_op      (alu_op),
        .alu_a_sel   (alu_a_sel),
        .alu_b_sel   (alu_b_sel),
        .reg_we      (reg_we),
        .reg_src     (reg_src),
        .sp_we       (sp_we),
        .is_pop      (is_pop),
        .retire      (retire),
        .retired_cnt (retired_cnt),
`ifdef ILLEGAL_TRAP_EN
        .trap        (trap),
`endif
        .mem_err     (mem_err)
    );

    // Free-running 10 ns clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hard stop in case the sequence never reaches its end
    initial begin
        #100000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic runV, input logic imemRdy,
                                 input logic [15:0] instrV, input logic dmemRdy,
                                 input logic zeroV);
        run               = runV;
        memBus.imem_ready = imemRdy;
        memBus.instr      = instrV;
        memBus.dmem_ready = dmemRdy;
        alu_zero          = zeroV;
        #1;
    endtask

    task automatic nextCycle();
        @(negedge clk);
    endtask

    // Present one word on the fetch port, then pass the quiet DECODE cycle
    task automatic fetchInstr(input logic [15:0] word);
        applyStimulus(1'b1, 1'b1, word, 1'b0, 1'b0);
        checkOutput("fetch_ir_load", 32'(ir_load), 32'd1);
        nextCycle();
        applyStimulus(1'b1, 1'b0, 16'h0000, 1'b0, 1'b0);
        checkOutput("decode_quiet", {28'd0, pc_write, reg_we, memBus.imem_req, memBus.dmem_req}, 32'd0);
        nextCycle();
    endtask

    initial begin
        reset_n = 1'b0;
        applyStimulus(1'b1, 1'b0, 16'h0000, 1'b0, 1'b0);
        nextCycle();
        nextCycle();
        #1;
        checkOutput("reset_imem_req", 32'(memBus.imem_req), 32'd0);
        checkOutput("reset_retired_cnt", 32'(retired_cnt), 32'd0);
        checkOutput("reset_mem_err", 32'(mem_err), 32'd0);
        checkOutput("reset_pc_write", 32'(pc_write), 32'd0);
        nextCycle();

        reset_n = 1'b1;
        applyStimulus(1'b0, 1'b1, 16'h0123, 1'b0, 1'b0);
        checkOutput("run0_imem_req", 32'(memBus.imem_req), 32'd0);
        checkOutput("run0_ir_load", 32'(ir_load), 32'd0);
        nextCycle();

        // add 0x0123 with imem_ready on the second request cycle
        applyStimulus(1'b1, 1'b0, 16'h0000, 1'b0, 1'b0);
        checkOutput("add_req_wait", 32'(memBus.imem_req), 32'd1);
        checkOutput("add_no_load", 32'(ir_load), 32'd0);
        nextCycle();
        fetchInstr(16'h0123);
        applyStimulus(1'b1, 1'b0, 16'h0000, 1'b0, 1'b0);
        checkOutput("add_reg_we", 32'(reg_we), 32'd1);
        checkOutput("add_alu_op", 32'(alu_op), 32'd0);
        checkOutput("add_pc_src", 32'(pc_src), 32'd0);
        checkOutput("add_pc_write", 32'(pc_write), 32'd1);
        checkOutput("add_retire", 32'(retire), 32'd1);
        nextCycle();
        applyStimulus(1'b1, 1'b0, 16'h0000, 1'b0, 1'b0);
        checkOutput("add_retired_cnt", 32'(retired_cnt), 32'd1);
        checkOutput("add_retire_once", 32'(retire), 32'd0);

        // shr 0x3A52
        fetchInstr(16'h3A52);
        applyStimulus(1'b1, 1'b0, 16'h0000, 1'b0, 1'b0);
        checkOutput("shr_alu_op", 32'(alu_op), 32'd6);
        checkOutput("shr_a_sel", 32'(alu_a_sel), 32'd2);
        checkOutput("shr_b_sel", 32'(alu_b_sel), 32'd2);
        checkOutput("shr_reg_we", 32'(reg_we), 32'd1);
        nextCycle();

        // beq 0xD123 taken and not taken
        fetchInstr(16'hD123);
        applyStimulus(1'b1, 1'b0, 16'h0000, 1'b0, 1'b1);
        checkOutput("beq_taken_pc_src", 32'(pc_src), 32'd1);
        checkOutput("beq_taken_pc_write", 32'(pc_write), 32'd1);
        checkOutput("beq_alu_op", 32'(alu_op), 32'd1);
        checkOutput("beq_b_sel", 32'(alu_b_sel), 32'd1);
        checkOutput("beq_no_reg_we", 32'(reg_we), 32'd0);
        nextCycle();
        fetchInstr(16'hD123);
        applyStimulus(1'b1, 1'b0, 16'h0000, 1'b0, 1'b0);
        checkOutput("beq_nt_pc_src", 32'(pc_src), 32'd0);
        checkOutput("beq_nt_pc_write", 32'(pc_write), 32'd1);
        nextCycle();

        // push 0x6300, dmem_ready after three wait cycles
        fetchInstr(16'h6300);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 1'b0, 16'h0000, 1'b0, 1'b0);
            checkOutput("push_wait_req", 32'(memBus.dmem_req), 32'd1);
            checkOutput("push_wait_we", 32'(memBus.dmem_we), 32'd1);
            checkOutput("push_wait_sp_we", 32'(sp_we), 32'd0);
            checkOutput("push_wait_retire", 32'(retire), 32'd0);
            nextCycle();
        end
        applyStimulus(1'b1, 1'b0, 16'h0000, 1'b1, 1'b0);
        checkOutput("push_rdy_req", 32'(memBus.dmem_req), 32'd1);
        checkOutput("push_rdy_sp_we", 32'(sp_we), 32'd1);
        checkOutput("push_rdy_addr_sel", 32'(memBus.dmem_addr_sel), 32'd2);
        checkOutput("push_rdy_alu", {27'd0, alu_op, alu_a_sel}, {27'd0, 3'b001, 2'b01});
        checkOutput("push_rdy_retire", 32'(retire), 32'd1);
        checkOutput("push_rdy_pc_write", 32'(pc_write), 32'd1);
        nextCycle();
        applyStimulus(1'b1, 1'b0, 16'h0000, 1'b0, 1'b0);
        checkOutput("push_after_req", 32'(memBus.dmem_req), 32'd0);
        checkOutput("push_retired_cnt", 32'(retired_cnt), 32'd5);

        // lw 0x8400 with dmem_ready on the timeout cycle completes normally
        fetchInstr(16'h8400);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, 1'b0, 16'h0000, 1'b0, 1'b0);
            checkOutput("lwb_wait_req", 32'(memBus.dmem_req), 32'd1);
            nextCycle();
        end
        applyStimulus(1'b1, 1'b0, 16'h0000, 1'b1, 1'b0);
        checkOutput("lwb_reg_we", 32'(reg_we), 32'd1);
        checkOutput("lwb_reg_src", 32'(reg_src), 32'd1);
        checkOutput("lwb_retire", 32'(retire), 32'd1);
        nextCycle();
        applyStimulus(1'b1, 1'b0, 16'h0000, 1'b0, 1'b0);
        checkOutput("lwb_mem_err", 32'(mem_err), 32'd0);
        checkOutput("lwb_retired_cnt", 32'(retired_cnt), 32'd6);

        // lw 0x8400 with dmem_ready never asserted
        fetchInstr(16'h8400);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, 1'b0, 16'h0000, 1'b0, 1'b0);
            checkOutput("lwt_wait_req", 32'(memBus.dmem_req), 32'd1);
            checkOutput("lwt_wait_reg_we", 32'(reg_we), 32'd0);
            nextCycle();
        end
        applyStimulus(1'b1, 1'b0, 16'h0000, 1'b0, 1'b0);
        checkOutput("lwt_abort_req", 32'(memBus.dmem_req), 32'd0);
        checkOutput("lwt_abort_reg_we", 32'(reg_we), 32'd0);
        checkOutput("lwt_abort_retire", 32'(retire), 32'd0);
        checkOutput("lwt_abort_pc_write", 32'(pc_write), 32'd1);
        nextCycle();
        applyStimulus(1'b1, 1'b0, 16'h0000, 1'b0, 1'b0);
        checkOutput("lwt_mem_err", 32'(mem_err), 32'd1);
        checkOutput("lwt_fetch_req", 32'(memBus.imem_req), 32'd1);
        checkOutput("lwt_retired_cnt", 32'(retired_cnt), 32'd6);

        // sw 0x9000 interrupted by reset while waiting in MEM
        fetchInstr(16'h9000);
        applyStimulus(1'b1, 1'b0, 16'h0000, 1'b0, 1'b0);
        checkOutput("sw_req", 32'(memBus.dmem_req), 32'd1);
        checkOutput("sw_we", 32'(memBus.dmem_we), 32'd1);
        checkOutput("sw_addr_sel", 32'(memBus.dmem_addr_sel), 32'd1);
        reset_n = 1'b0;
        #1;
        checkOutput("rst_mid_req", 32'(memBus.dmem_req), 32'd0);
        checkOutput("rst_mid_we", 32'(memBus.dmem_we), 32'd0);
        checkOutput("rst_mid_imem_req", 32'(memBus.imem_req), 32'd0);
        checkOutput("rst_mid_mem_err", 32'(mem_err), 32'd0);
        checkOutput("rst_mid_retired_cnt", 32'(retired_cnt), 32'd0);
        nextCycle();
        reset_n = 1'b1;
        applyStimulus(1'b1, 1'b0, 16'h0000, 1'b1, 1'b0);
        checkOutput("rst_rel_imem_req", 32'(memBus.imem_req), 32'd1);
        checkOutput("rst_rel_dmem_req", 32'(memBus.dmem_req), 32'd0);
        nextCycle();

        // illegal unary sub-function 0x3A55
        fetchInstr(16'h3A55);
        applyStimulus(1'b1, 1'b0, 16'h0000, 1'b0, 1'b0);
`ifdef ILLEGAL_TRAP_EN
        checkOutput("ill_trap", 32'(trap), 32'd1);
        checkOutput("ill_pc_write", 32'(pc_write), 32'd0);
        checkOutput("ill_retire", 32'(retire), 32'd0);
        nextCycle();
        applyStimulus(1'b1, 1'b1, 16'h0123, 1'b0, 1'b0);
        checkOutput("ill_trap_hold", 32'(trap), 32'd1);
        checkOutput("ill_trap_no_fetch", 32'(memBus.imem_req), 32'd0);
`else
        checkOutput("ill_nop_pc_write", 32'(pc_write), 32'd1);
        checkOutput("ill_nop_pc_src", 32'(pc_src), 32'd0);
        checkOutput("ill_nop_retire", 32'(retire), 32'd1);
        checkOutput("ill_nop_reg_we", 32'(reg_we), 32'd0);
        nextCycle();
        applyStimulus(1'b1, 1'b0, 16'h0000, 1'b0, 1'b0);
        checkOutput("ill_nop_retired_cnt", 32'(retired_cnt), 32'd1);
        checkOutput("ill_nop_fetch", 32'(memBus.imem_req), 32'd1);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/multicycle_sequencer.md
Name: multicycle_sequencer

Overview:
- Multi-cycle control FSM for the 16-bit single-issue core; replaces the purely combinational control decode with a fetch/decode/execute/memory sequence.
- Drives PC, IR, register-file, SP, ALU-mux and data-memory controls, one phase per state.
- Handshakes with instruction and data memories via req/ready.
- Guards every data-memory access with a wait-cycle timeout.

Parameters:
- MEM_TIMEOUT, 15, max cycles dmem_req may wait for dmem_ready before abort (1..255)
- CNT_W, 16, width of retired-instruction counter

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- run  in  1  level; 0 holds FSM in FETCH without issuing imem_req
- instr  in  16  instruction word from instruction memory
- imem_ready  in  1  instr valid this cycle
- dmem_ready  in  1  data access complete this cycle
- alu_zero  in  1  ALU result == 0
- imem_req  out  1  instruction fetch request
- ir_load  out  1  capture instr into internal IR
- pc_write  out  1  update PC
- pc_src  out  2  00 PC+1, 01 branch target, 10 jump target
- alu_op  out  3  ALU function code
- alu_a_sel  out  2  00 s1, 01 SP, 10 imm4 shift amount
- alu_b_sel  out  2  00 const 1, 01 s2, 10 rd
- dmem_req  out  1  data access request
- dmem_we  out  1  data write
- dmem_addr_sel  out  2  00 lw addr, 01 sw addr, 10 SP, 11 s1[7:0]
- reg_we  out  1  register write strobe
- reg_src  out  1  0 ALU, 1 memory
- sp_we  out  1  SP write strobe
- is_pop  out  1  pop address select
- retire  out  1  one-cycle pulse per completed instruction
- retired_cnt  out  CNT_W  retired-instruction count, wraps
- mem_err  out  1  sticky; set on timeout

Behaviour:
- Reset (async, reset_n=0): state=FETCH, IR=0, timeout cnt=0, retired_cnt=0, mem_err=0, all strobes 0, all selects 00.
- Strobes are decoded from state plus IR; IR, counters and mem_err are registered.
- Release from reset mid-access: no pending request is remembered; fetch restarts.
- FETCH: imem_req=run. On imem_ready&run: ir_load=1, go to DECODE. Otherwise hold.
- DECODE: one cycle, no strobes. Next state by IR[15:12]:
  - 0000/0001/0010/0100/0011 (ALU), 1101 (beq), 1100 (jmp) -> EXEC
  - 1000/1001/1111/0110/1110 -> MEM
  - any other opcode -> per ILLEGAL_TRAP_EN
- EXEC, ALU class: reg_we=1, reg_src=0, pc_write=1, pc_src=00.
  - alu_op: add 000, sub 001, nand 010, nor 011.
  - opcode 0011: IR[3:0] 0000 neg 100, 0001 sar 101, 0010 shr 110, 0011 shl 111; shifts use alu_a_sel=10, alu_b_sel=10.
  - opcode 0011 with IR[3:0]>0011 is illegal.
- EXEC, beq: alu_op=001, a=00, b=01, pc_write=1, pc_src=01 if alu_zero else 00.
- EXEC, jmp: pc_write=1, pc_src=10.
- Every EXEC cycle: retire=1, next state FETCH.
- MEM: dmem_req=1 held constant until dmem_ready.
  - lw: addr_sel=00, reg_src=1.
  - sw: addr_sel=01, dmem_we=1.
  - custom lw: addr_sel=11, reg_src=1.
  - push: addr_sel=10, dmem_we=1, alu_op=001, alu_a_sel=01.
  - pop: addr_sel=10, is_pop=1, reg_src=1, alu_op=000, alu_a_sel=01.
- MEM, on the dmem_ready cycle only:
  - reg_we=1 for loads and pop; sp_we=1 for push and pop.
  - pc_write=1 with pc_src=00; retire=1; go to FETCH.
- Timeout: counter runs while in MEM without dmem_ready; cleared on leaving MEM.
  - When count == MEM_TIMEOUT, with dmem_ready still low that cycle: drop dmem_req, mem_err=1, no reg/SP write.
  - Same cycle: pc_write=1 (skip instruction), no retire, go to FETCH.
- dmem_ready on the timeout cycle: completes normally; no error.
- retired_cnt increments on retire and wraps from all-ones to 0.
- run=0 is sampled only in FETCH; an instruction in flight always completes.

Optional Feature:
- Macro ILLEGAL_TRAP_EN.
- Defined: illegal opcode goes DECODE->TRAP. TRAP asserts output trap=1 (extra port) and holds all other strobes 0. Only reset exits TRAP.
- Undefined: illegal opcode is a NOP: EXEC with pc_write=1, pc_src=00, retire=1, no other strobes. The trap port is absent.

Decomposition:
- Shared package seq_pkg holds:
  - opcode constants
  - state enum: FETCH, DECODE, EXEC, MEM, TRAP
  - alu_op codes
  - alu_a/alu_b/dmem_addr/pc_src select constants
- One sub-module, instr_class_decode: combinational IR -> {class, alu_op, selects, illegal}.
- The sequencer FSM, timeout counter and retire counter stay in the top.

Test Plan:
- Fetch add (0x0123), imem_ready on 2nd req cycle -> DECODE next, EXEC reg_we=1 alu_op=000 pc_src=00, retire once, retired_cnt=1.
- Shift 0x3A52 (shr) -> EXEC alu_op=110, alu_a_sel=10, alu_b_sel=10. 0x3A55 -> trap=1 with ILLEGAL_TRAP_EN, NOP without.
- beq 0xD123:
  - alu_zero=1 -> pc_src=01.
  - alu_zero=0 -> pc_src=00.
  - pc_write=1 in both cases.
- push 0x6300, dmem_ready after 3 wait cycles -> dmem_req held 4 cycles, dmem_we=1, sp_we=1 only on the ready cycle.
- lw 0x8400, MEM_TIMEOUT=4, dmem_ready never asserted -> mem_err=1, reg_we never asserted, no retire, state FETCH.
- Drop reset_n mid-MEM -> all strobes 0 immediately, mem_err=0, retired_cnt=0. After release, FETCH with imem_req=run.
